// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Package : conv_pkg
//  Purpose : Shared helpers for the multi-filter binary convolution engine:
//            width functions, accumulator-width bound, slice/index helpers and
//            the output-register state type.
//  Revision: 1.0 - initial multi-filter, multi-channel release
// ============================================================================
package conv_pkg;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Bits needed to hold an index/count, never less than one.
   function automatic int width_of(input int count);
      return (clog2(count) < 1) ? 1 : clog2(count);
   endfunction

   // Smallest signed accumulator that cannot overflow for a full group.
   function automatic int min_acc_width(input int data_width, input int lanes,
                                        input int max_in_ch);
      return data_width + 1 + clog2(lanes * max_in_ch);
   endfunction

   // LSB of window lane i inside the packed pixel bus.
   function automatic int lane_lsb(input int lane, input int data_width);
      return lane * data_width;
   endfunction

   // LSB of filter f inside the packed result bus.
   function automatic int filter_lsb(input int filter, input int acc_width);
      return filter * acc_width;
   endfunction

   // Weight-bank entry holding the kernel for filter f, input channel c.
   function automatic int weight_entry(input int filter, input int chan,
                                       input int max_in_ch);
      return filter * max_in_ch + chan;
   endfunction

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

endpackage
`default_nettype wire

// File: rtl/bin_dot.sv
`default_nettype none
// ============================================================================
//  Module  : bin_dot
//  Purpose : Combinational binary-weight dot product for one filter. Each lane
//            contributes +x (weight bit 1) or -x (weight bit 0); pixels are
//            zero-extended and the sum wraps in ACC_WIDTH two's complement.
//  Ports   : pixels  - LANES packed unsigned pixels
//            weights - one sign bit per lane
//            dot     - signed sum
//  Revision: 1.0 - initial release
// ============================================================================
module bin_dot
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 9,
   parameter int ACC_WIDTH  = 16
) (
   input  logic [DATA_WIDTH*LANES-1:0] pixels,
   input  logic [LANES-1:0]            weights,
   output logic signed [ACC_WIDTH-1:0] dot
);

   logic [ACC_WIDTH-1:0] sum;
   logic [ACC_WIDTH-1:0] x;

   always_comb begin
      sum = '0;
      x   = '0;
      for (int i = 0; i < LANES; i++) begin
         x = {{(ACC_WIDTH-DATA_WIDTH){1'b0}},
              pixels[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]};
         if (weights[i]) sum = sum + x;
         else            sum = sum - x;
      end
   end

   assign dot = sum;

endmodule
`default_nettype wire

// File: rtl/conv_engine_mc.sv
`default_nettype none
// ============================================================================
//  Module  : conv_engine_mc
//  Purpose : Multi-filter, multi-input-channel binary convolution. One KxK
//            window (one input channel) per accepted beat; NUM_FILTERS
//            accumulators sum across a group of input channels and the
//            (optionally ReLU'd) vector is presented on an AXI-stream master.
//  Ports   : clk, rstn           - clock, asynchronous active-low reset
//            wr_weight_*, weight_array - kernel bank write (stalls stream)
//            cfg_in_ch, cfg_relu - group size (0 -> 1), ReLU enable
//            s_t*                - window stream slave
//            m_t*                - result stream master
//            frame_done          - pulse after an m_tlast beat is consumed
//  Revision: 1.0 - initial release
// ============================================================================
module conv_engine_mc
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int KERNEL_SIZE = 3,
   parameter int NUM_FILTERS = 4,
   parameter int MAX_IN_CH   = 8,
   parameter int ACC_WIDTH   = 16
) (
   input  logic                                         clk,
   input  logic                                         rstn,
   input  logic                                         wr_weight_en,
   input  logic [width_of(NUM_FILTERS*MAX_IN_CH)-1:0]   wr_weight_addr,
   input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0]           weight_array,
   input  logic [width_of(MAX_IN_CH+1)-1:0]             cfg_in_ch,
   input  logic                                         cfg_relu,
   input  logic                                         s_tvalid,
   input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] s_tdata,
   input  logic                                         s_tlast,
   output logic                                         s_tready,
   output logic                                         m_tvalid,
   input  logic                                         m_tready,
   output logic [NUM_FILTERS*ACC_WIDTH-1:0]             m_tdata,
   output logic                                         m_tlast,
   output logic                                         frame_done
);

   localparam int LANES   = KERNEL_SIZE * KERNEL_SIZE;
   localparam int ENTRIES = NUM_FILTERS * MAX_IN_CH;
   localparam int ADDR_W  = width_of(ENTRIES);
   localparam int CFG_W   = width_of(MAX_IN_CH + 1);
   localparam int IDX_W   = width_of(MAX_IN_CH);

   if (ACC_WIDTH < min_acc_width(DATA_WIDTH, LANES, MAX_IN_CH)) begin : g_acc_width_check
      $error("conv_engine_mc: ACC_WIDTH too small for DATA_WIDTH/KERNEL_SIZE/MAX_IN_CH");
   end

   logic [LANES-1:0]  wbank [ENTRIES];
   logic [IDX_W-1:0]  ch_idx;
   logic [CFG_W-1:0]  n_held;
   logic [CFG_W-1:0]  cfg_n;
   logic [CFG_W-1:0]  n_now;
   logic              accept;
   logic              close;
   out_state_t        state;

   // ------------------------------------------------------------------------
   // Weight bank: one-hot decode so addresses beyond the bank simply match
   // no entry.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int e = 0; e < ENTRIES; e++) wbank[e] <= '0;
      end else begin
         for (int e = 0; e < ENTRIES; e++) begin
            if (wr_weight_en && (wr_weight_addr == ADDR_W'(e))) wbank[e] <= weight_array;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Group control. Group size is taken from cfg_in_ch only on the first beat
   // of a group; later beats use the held copy so a mid-group cfg change
   // cannot shorten or stretch the group.
   // ------------------------------------------------------------------------
   always_comb begin
      cfg_n = cfg_in_ch;
      if (cfg_in_ch == '0)                     cfg_n = CFG_W'(1);
      else if (cfg_in_ch > CFG_W'(MAX_IN_CH))  cfg_n = CFG_W'(MAX_IN_CH);
   end

   assign n_now    = (ch_idx == '0) ? cfg_n : n_held;
   assign s_tready = rstn && !wr_weight_en && (!m_tvalid || m_tready);
   assign accept   = s_tvalid && s_tready;
   assign close    = accept && ((CFG_W'(ch_idx) + CFG_W'(1) == n_now) || s_tlast);

   // ------------------------------------------------------------------------
   // Per-filter datapath: dot product, accumulator and output register.
   // ------------------------------------------------------------------------
   for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_filter
      logic [LANES-1:0]            wsel;
      logic signed [ACC_WIDTH-1:0] dot;
      logic signed [ACC_WIDTH-1:0] acc;
      logic signed [ACC_WIDTH-1:0] sum;
      logic signed [ACC_WIDTH-1:0] res;
      logic signed [ACC_WIDTH-1:0] res_q;

      assign wsel = wbank[ADDR_W'(weight_entry(f, 0, MAX_IN_CH)) + ADDR_W'(ch_idx)];

      bin_dot #(
         .DATA_WIDTH (DATA_WIDTH),
         .LANES      (LANES),
         .ACC_WIDTH  (ACC_WIDTH)
      ) u_dot (
         .pixels  (s_tdata),
         .weights (wsel),
         .dot     (dot)
      );

      assign sum = acc + dot;
      assign res = (cfg_relu && sum[ACC_WIDTH-1]) ? '0 : sum;

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            acc   <= '0;
            res_q <= '0;
         end else if (accept) begin
            acc <= close ? '0 : sum;
            if (close) res_q <= res;
         end
      end

      assign m_tdata[filter_lsb(f, ACC_WIDTH) +: ACC_WIDTH] = res_q;
   end

   // ------------------------------------------------------------------------
   // Channel counter and output-register state machine. A close while FULL
   // can only happen when m_tready is high (s_tready gates it), so the
   // reload and the pop coincide.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= EMPTY;
         m_tvalid   <= 1'b0;
         m_tlast    <= 1'b0;
         frame_done <= 1'b0;
         ch_idx     <= '0;
         n_held     <= '0;
      end else begin
         frame_done <= m_tvalid && m_tready && m_tlast;

         if (accept) begin
            if (ch_idx == '0) n_held <= cfg_n;
            ch_idx <= close ? '0 : ch_idx + IDX_W'(1);
         end

         case (state)
            EMPTY: begin
               if (close) begin
                  state    <= FULL;
                  m_tvalid <= 1'b1;
                  m_tlast  <= s_tlast;
               end
            end
            FULL: begin
               if (close) begin
                  m_tlast <= s_tlast;
               end else if (m_tready) begin
                  state    <= EMPTY;
                  m_tvalid <= 1'b0;
               end
            end
            default: begin
               state    <= EMPTY;
               m_tvalid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
